dbnc_bit_array: RTL and testbench

- W-channel input conditioner: generate loop instantiates one per-bit channel per input bit.
- Each channel synchronises its bit, debounces it over STABLE cycles and emits one-cycle rise/fall pulses.
- Aggregate event counter totals all edges.
- Sits between raw asynchronous status pins and the clocked control logic.

---
 rtl/dbnc_pkg.sv | 37 +++
 rtl/dbnc_chan.sv | 72 +++++++
 rtl/dbnc_bit_array.sv | 60 ++++++
 tb/tb_dbnc_bit_array.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbnc_pkg.sv
// Shared helpers for the debounced bit array: counter sizing, pulse
// population count and the saturating event accumulator.
package dbnc_pkg;

  localparam int POP_MAX = 256;  // widest pulse vector popcount accepts
  localparam int SAT_MAX = 64;   // widest accumulator sat_add accepts

  function automatic int cnt_width(input int stable);
    int w;
    w = $clog2(stable);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // acc + inc, clamped to 2^width-1; the one-bit-wider sum cannot wrap.
  function automatic logic [SAT_MAX-1:0] sat_add(input logic [SAT_MAX-1:0] acc,
                                                 input logic [SAT_MAX-1:0] inc,
                                                 input int width);
    logic [SAT_MAX:0] sum;
    logic [SAT_MAX:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = '0;
    for (int i = 0; i < SAT_MAX; i++) begin
      if (i < width) lim[i] = 1'b1;
    end
    return (sum > lim) ? lim[SAT_MAX-1:0] : sum[SAT_MAX-1:0];
  endfunction

endpackage

// File: rtl/dbnc_chan.sv
// One conditioned input: two-flop synchroniser, mismatch counter, debounced
// level and registered one-cycle rise/fall pulses.
module dbnc_chan
  import dbnc_pkg::*;
#(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  input  logic en_i,
  input  logic clr_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(STABLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (clr_i) begin
      cnt_d    = '0;
      stable_d = 1'b0;
    end else if (en_i) begin
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        stable_d = s2_q;
        rise_d   = s2_q;
        fall_d   = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // The synchroniser ignores clr_i so a held-high input re-debounces after a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      s1_q     <= d_i;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/dbnc_bit_array.sv
// W-channel input conditioner: per-bit debounce channels plus an aggregate,
// saturating count of every rise and fall pulse.
module dbnc_bit_array
  import dbnc_pkg::*;
#(
  parameter int W      = 6,
  parameter int STABLE = 4,
  parameter int EVT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     foo_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [W-1:0]     stable_o,
  output logic [W-1:0]     rise_o,
  output logic [W-1:0]     fall_o,
  output logic             any_evt_o,
  output logic [EVT_W-1:0] evt_cnt_o
);

  logic [EVT_W-1:0] evt_q, evt_d;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_chan
      dbnc_chan #(
        .STABLE (STABLE)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (foo_i[gi]),
        .en_i     (en_i),
        .clr_i    (clr_i),
        .stable_o (stable_o[gi]),
        .rise_o   (rise_o[gi]),
        .fall_o   (fall_o[gi])
      );
    end
  endgenerate

  assign any_evt_o = |(rise_o | fall_o);

  // Counts the already-registered pulses, so the total trails them by a cycle.
  always_comb begin
    evt_d = '0;
    if (!clr_i) begin
      evt_d = EVT_W'(sat_add(SAT_MAX'(evt_q),
                             SAT_MAX'(popcount(POP_MAX'(rise_o | fall_o))),
                             EVT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_q <= '0;
    else        evt_q <= evt_d;
  end

  assign evt_cnt_o = evt_q;

endmodule

// File: tb/tb_dbnc_bit_array.sv
// Directed bench for dbnc_bit_array: expectations are queued per cycle as
// stimulus is applied and checked on the falling edge of that cycle.
module tb_dbnc_bit_array;

  localparam int W      = 6;
  localparam int STABLE = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] foo_i = '0;
  logic         en_i = 1'b1;
  logic         clr_i = 1'b0;

  logic [W-1:0] stable_o, rise_o, fall_o;
  logic         any_evt_o;
  logic [7:0]   evt_cnt_o;
  logic [W-1:0] stable_s, rise_s, fall_s;
  logic         any_s;
  logic [3:0]   evt_s;

  dbnc_bit_array #(.W(W), .STABLE(STABLE), .EVT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .foo_i(foo_i), .en_i(en_i), .clr_i(clr_i),
    .stable_o(stable_o), .rise_o(rise_o), .fall_o(fall_o),
    .any_evt_o(any_evt_o), .evt_cnt_o(evt_cnt_o)
  );

  dbnc_bit_array #(.W(W), .STABLE(STABLE), .EVT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .foo_i(foo_i), .en_i(en_i), .clr_i(clr_i),
    .stable_o(stable_s), .rise_o(rise_s), .fall_o(fall_s),
    .any_evt_o(any_s), .evt_cnt_o(evt_s)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int         cyc;
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  localparam int S_STABLE = 0, S_RISE = 1, S_FALL = 2, S_ANY = 3,
                 S_EVT = 4, S_EVT_SAT = 5, S_STABLE_SAT = 6;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_STABLE:     return {2'b0, stable_o};
      S_RISE:       return {2'b0, rise_o};
      S_FALL:       return {2'b0, fall_o};
      S_ANY:        return {7'b0, any_evt_o};
      S_EVT:        return evt_cnt_o;
      S_EVT_SAT:    return {4'b0, evt_s};
      S_STABLE_SAT: return {2'b0, stable_s};
      default:      return 8'hxx;
    endcase
  endfunction

  function automatic void expect_at(input int cyc, input string tag,
                                    input int sel, input logic [7:0] val);
    exp_t e;
    int   idx;
    e.cyc = cyc; e.tag = tag; e.sel = sel; e.val = val;
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > cyc) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp_v, cycle);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cycle) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s: expectation for cycle %0d missed, now %0d", e.tag, e.cyc, cycle);
      end else begin
        check(e.tag, observe(e.sel), e.val);
      end
    end
  endtask

  task automatic wait_until(input int cyc);
    while (cycle < cyc) tick();
  endtask

  initial begin
    int c;

    // Reset held with all inputs high: everything must read zero.
    foo_i = 6'h3F;
    repeat (3) tick();
    check("rst_stable", {2'b0, stable_o}, 8'h00);
    check("rst_rise", {2'b0, rise_o}, 8'h00);
    check("rst_fall", {2'b0, fall_o}, 8'h00);
    check("rst_any", {7'b0, any_evt_o}, 8'h00);
    check("rst_evt", evt_cnt_o, 8'h00);
    check("rst_sat_stable", {2'b0, stable_s}, 8'h00);
    check("rst_sat_rise", {2'b0, rise_s}, 8'h00);
    check("rst_sat_fall", {2'b0, fall_s}, 8'h00);
    check("rst_sat_any", {7'b0, any_s}, 8'h00);
    check("rst_sat_evt", {4'b0, evt_s}, 8'h00);

    // Release: sampling edge c+1, flip after edge c+1+STABLE+1.
    c = cycle;
    rst_n = 1'b1;
    expect_at(c + 5, "rel_stable_pre", S_STABLE, 8'h00);
    expect_at(c + 6, "rel_stable", S_STABLE, 8'h3F);
    expect_at(c + 6, "rel_rise", S_RISE, 8'h3F);
    expect_at(c + 6, "rel_fall", S_FALL, 8'h00);
    expect_at(c + 6, "rel_any", S_ANY, 8'h01);
    expect_at(c + 6, "rel_evt_lag", S_EVT, 8'd0);
    expect_at(c + 6, "rel_sat_stable", S_STABLE_SAT, 8'h3F);
    expect_at(c + 7, "rel_rise_end", S_RISE, 8'h00);
    expect_at(c + 7, "rel_any_end", S_ANY, 8'h00);
    expect_at(c + 7, "rel_evt", S_EVT, 8'd6);
    expect_at(c + 7, "rel_sat_evt", S_EVT_SAT, 8'd6);
    wait_until(c + 8);

    // All channels fall.
    c = cycle;
    foo_i = 6'h00;
    expect_at(c + 6, "allfall_stable", S_STABLE, 8'h00);
    expect_at(c + 6, "allfall_fall", S_FALL, 8'h3F);
    expect_at(c + 6, "allfall_rise", S_RISE, 8'h00);
    expect_at(c + 7, "allfall_evt", S_EVT, 8'd12);
    expect_at(c + 7, "allfall_sat_evt", S_EVT_SAT, 8'd12);
    wait_until(c + 8);

    // Glitch of STABLE-1 samples on channel 2 is rejected.
    c = cycle;
    foo_i = 6'h04;
    for (int k = 1; k <= 10; k++) expect_at(c + k, "glitch_no_rise", S_RISE, 8'h00);
    expect_at(c + 10, "glitch_stable", S_STABLE, 8'h00);
    expect_at(c + 10, "glitch_evt", S_EVT, 8'd12);
    wait_until(c + 3);
    foo_i = 6'h00;
    wait_until(c + 11);

    // Six-cycle pulse on channel 2: one rise, then one fall.
    c = cycle;
    foo_i = 6'h04;
    expect_at(c + 5, "pulse_pre", S_STABLE, 8'h00);
    expect_at(c + 6, "pulse_rise", S_RISE, 8'h04);
    expect_at(c + 6, "pulse_rise_nofall", S_FALL, 8'h00);
    expect_at(c + 6, "pulse_stable_hi", S_STABLE, 8'h04);
    expect_at(c + 7, "pulse_rise_once", S_RISE, 8'h00);
    expect_at(c + 7, "pulse_evt1", S_EVT, 8'd13);
    expect_at(c + 11, "pulse_hold_hi", S_STABLE, 8'h04);
    expect_at(c + 12, "pulse_fall", S_FALL, 8'h04);
    expect_at(c + 12, "pulse_fall_norise", S_RISE, 8'h00);
    expect_at(c + 12, "pulse_stable_lo", S_STABLE, 8'h00);
    expect_at(c + 13, "pulse_fall_once", S_FALL, 8'h00);
    expect_at(c + 13, "pulse_evt2", S_EVT, 8'd14);
    wait_until(c + 6);
    foo_i = 6'h00;
    wait_until(c + 14);

    // Enable freeze on channel 0 after two mismatch edges.
    c = cycle;
    foo_i = 6'h01;
    for (int k = 5; k <= 15; k++) begin
      expect_at(c + k, "freeze_stable", S_STABLE, 8'h00);
      expect_at(c + k, "freeze_no_rise", S_RISE, 8'h00);
    end
    expect_at(c + 16, "freeze_resume_stable", S_STABLE, 8'h01);
    expect_at(c + 16, "freeze_resume_rise", S_RISE, 8'h01);
    expect_at(c + 17, "freeze_evt", S_EVT, 8'd15);
    expect_at(c + 17, "freeze_sat_evt", S_EVT_SAT, 8'd15);
    wait_until(c + 4);
    en_i = 1'b0;
    wait_until(c + 14);
    en_i = 1'b1;
    wait_until(c + 18);

    // Clear lands on the edge that would have flipped channel 0 low.
    c = cycle;
    foo_i = 6'h00;
    expect_at(c + 5, "clr_pre_stable", S_STABLE, 8'h01);
    expect_at(c + 6, "clr_no_fall", S_FALL, 8'h00);
    expect_at(c + 6, "clr_stable", S_STABLE, 8'h00);
    expect_at(c + 6, "clr_any", S_ANY, 8'h00);
    expect_at(c + 6, "clr_evt", S_EVT, 8'd0);
    expect_at(c + 6, "clr_sat_evt", S_EVT_SAT, 8'd0);
    expect_at(c + 7, "clr_after_fall", S_FALL, 8'h00);
    expect_at(c + 7, "clr_after_evt", S_EVT, 8'd0);
    wait_until(c + 5);
    clr_i = 1'b1;
    wait_until(c + 6);
    clr_i = 1'b0;
    wait_until(c + 8);

    // Toggle every channel: 4-bit counter climbs 6, 12, then pins at 15.
    for (int t = 0; t < 4; t++) begin
      logic [7:0] main_v, sat_v;
      c = cycle;
      foo_i = (t % 2 == 0) ? 6'h3F : 6'h00;
      main_v = 8'(6 * (t + 1));
      sat_v  = (t == 0) ? 8'd6 : (t == 1) ? 8'd12 : 8'd15;
      expect_at(c + 6, (t % 2 == 0) ? "sat_rise" : "sat_fall",
                (t % 2 == 0) ? S_RISE : S_FALL, 8'h3F);
      expect_at(c + 7, "sat_main_evt", S_EVT, main_v);
      expect_at(c + 7, "sat_evt", S_EVT_SAT, sat_v);
      wait_until(c + 8);
    end

    // Asynchronous reset while a rise pulse is live.
    c = cycle;
    foo_i = 6'h01;
    wait_until(c + 6);
    #2;
    check("arst_pre_rise", {2'b0, rise_o}, 8'h01);
    check("arst_pre_stable", {2'b0, stable_o}, 8'h01);
    check("arst_pre_evt", evt_cnt_o, 8'd24);
    rst_n = 1'b0;
    #1;
    check("arst_rise", {2'b0, rise_o}, 8'h00);
    check("arst_stable", {2'b0, stable_o}, 8'h00);
    check("arst_any", {7'b0, any_evt_o}, 8'h00);
    check("arst_evt", evt_cnt_o, 8'd0);
    check("arst_sat_evt", {4'b0, evt_s}, 8'd0);
    tick();

    check("sb_drained", 8'(sb.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
